// File: rtl/axi_perf_monitor.sv
`default_nettype none
// ============================================================================
// Module   : axi_perf_monitor
// Brief    : AXI traffic/performance monitor on the CPU-side master port.
//            Per-slave read/write counts, read latency sum/max, cycles,
//            retired instructions, stalls and protocol-error counters, all
//            saturating, read back through a one-cycle-latency register port.
// Options  : define PERF_HANG_DETECT_EN to enable the sticky hang_irq flag
//            raised when a read stays outstanding for HANG_LIMIT cycles.
// Revision : 1.0 - initial release
// ============================================================================
module axi_perf_monitor #(
  parameter int NUM_SLAVES = 2,
  parameter int CNT_WIDTH  = 32,
  parameter int IDX_WIDTH  = 8,
  parameter int HANG_LIMIT = 256,
  localparam int SEL_W     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mon_en,
  input  logic                 mon_clear,
  input  logic                 arvalid,
  input  logic                 arready,
  input  logic [SEL_W-1:0]     ar_sel,
  input  logic                 rvalid,
  input  logic                 rready,
  input  logic                 awvalid,
  input  logic                 awready,
  input  logic [SEL_W-1:0]     aw_sel,
  input  logic                 instr_ret,
  input  logic                 cpu_stall,
  input  logic                 reg_rd_en,
  input  logic [IDX_WIDTH-1:0] reg_idx,
  output logic [CNT_WIDTH-1:0] reg_rdata,
  output logic                 reg_rvalid,
  output logic                 rd_busy,
  output logic                 hang_irq
);

  localparam logic [CNT_WIDTH-1:0] c_one     = CNT_WIDTH'(1);
  localparam logic [SEL_W:0]       c_sel_lim = (SEL_W+1)'(NUM_SLAVES);

  // Elaboration-time guard against unsupported configurations
  generate
    if (NUM_SLAVES < 1 || CNT_WIDTH < 8 || CNT_WIDTH > 32 || HANG_LIMIT < 1) begin : g_param_check
      $error("axi_perf_monitor: unsupported parameter value");
    end
  endgenerate

  // Saturating add: a sum that overflows clamps to all-ones instead of wrapping
  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [CNT_WIDTH-1:0] b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
  endfunction

  // Global counters
  logic [CNT_WIDTH-1:0] cycles_q, cycles_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic [CNT_WIDTH-1:0] stalls_q, stalls_d;
  logic [CNT_WIDTH-1:0] prot_err_q, prot_err_d;

  // Per-slave counters
  logic [CNT_WIDTH-1:0] rd_cnt_q  [NUM_SLAVES];
  logic [CNT_WIDTH-1:0] rd_cnt_d  [NUM_SLAVES];
  logic [CNT_WIDTH-1:0] wr_cnt_q  [NUM_SLAVES];
  logic [CNT_WIDTH-1:0] wr_cnt_d  [NUM_SLAVES];
  logic [CNT_WIDTH-1:0] lat_sum_q [NUM_SLAVES];
  logic [CNT_WIDTH-1:0] lat_sum_d [NUM_SLAVES];
  logic [CNT_WIDTH-1:0] lat_max_q [NUM_SLAVES];
  logic [CNT_WIDTH-1:0] lat_max_d [NUM_SLAVES];

  // Outstanding-read tracker; the timer equals the latency the read would
  // have if its R handshake happened on the next edge
  logic                 rd_busy_q, rd_busy_d;
  logic [SEL_W-1:0]     rd_sel_q, rd_sel_d;
  logic [CNT_WIDTH-1:0] timer_q, timer_d;

  // Register read port
  logic [CNT_WIDTH-1:0] rdata_q;
  logic                 rvalid_q;
  logic [CNT_WIDTH-1:0] w_rd_val;

  logic       w_ar_hs;
  logic       w_r_hs;
  logic       w_aw_hs;
  logic       w_ar_sel_ok;
  logic       w_aw_sel_ok;
  logic [1:0] w_perr_inc;

  assign w_ar_hs     = arvalid & arready;
  assign w_r_hs      = rvalid & rready;
  assign w_aw_hs     = awvalid & awready;
  assign w_ar_sel_ok = ({1'b0, ar_sel} < c_sel_lim);
  assign w_aw_sel_ok = ({1'b0, aw_sel} < c_sel_lim);

  // Next-state computation for all counters and the read tracker
  always_comb begin
    cycles_d   = cycles_q;
    retired_d  = retired_q;
    stalls_d   = stalls_q;
    prot_err_d = prot_err_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    lat_sum_d  = lat_sum_q;
    lat_max_d  = lat_max_q;
    rd_busy_d  = rd_busy_q;
    rd_sel_d   = rd_sel_q;
    timer_d    = timer_q;
    w_perr_inc = 2'd0;

    if (rd_busy_q) begin
      timer_d = sat_add(timer_q, c_one);
    end

    // Retire the outstanding read; a stray R (no read, no AR) is an error.
    // R together with an AR while idle is ignored: it cannot belong to the new read.
    if (w_r_hs && rd_busy_q) begin
      rd_busy_d = 1'b0;
      timer_d   = '0;
      if (mon_en) begin
        for (int s = 0; s < NUM_SLAVES; s++) begin
          if (rd_sel_q == SEL_W'(s)) begin
            lat_sum_d[s] = sat_add(lat_sum_q[s], timer_q);
            if (timer_q > lat_max_q[s]) begin
              lat_max_d[s] = timer_q;
            end
          end
        end
      end
    end else if (w_r_hs && !w_ar_hs) begin
      w_perr_inc = w_perr_inc + 2'd1;
    end

    // A new read always starts tracking, even when it abandons an older one
    if (w_ar_hs) begin
      if (rd_busy_q && !w_r_hs) begin
        w_perr_inc = w_perr_inc + 2'd1;
      end
      if (!w_ar_sel_ok) begin
        w_perr_inc = w_perr_inc + 2'd1;
      end else if (mon_en) begin
        for (int s = 0; s < NUM_SLAVES; s++) begin
          if (ar_sel == SEL_W'(s)) begin
            rd_cnt_d[s] = sat_add(rd_cnt_q[s], c_one);
          end
        end
      end
      rd_busy_d = 1'b1;
      rd_sel_d  = ar_sel;
      timer_d   = c_one;
    end

    if (w_aw_hs) begin
      if (!w_aw_sel_ok) begin
        w_perr_inc = w_perr_inc + 2'd1;
      end else if (mon_en) begin
        for (int s = 0; s < NUM_SLAVES; s++) begin
          if (aw_sel == SEL_W'(s)) begin
            wr_cnt_d[s] = sat_add(wr_cnt_q[s], c_one);
          end
        end
      end
    end

    if (mon_en) begin
      cycles_d   = sat_add(cycles_q, c_one);
      prot_err_d = sat_add(prot_err_q, CNT_WIDTH'(w_perr_inc));
      if (instr_ret) begin
        retired_d = sat_add(retired_q, c_one);
      end
      if (cpu_stall) begin
        stalls_d = sat_add(stalls_q, c_one);
      end
    end

    // Clear wins over every same-cycle event
    if (mon_clear) begin
      cycles_d   = '0;
      retired_d  = '0;
      stalls_d   = '0;
      prot_err_d = '0;
      rd_cnt_d   = '{default: '0};
      wr_cnt_d   = '{default: '0};
      lat_sum_d  = '{default: '0};
      lat_max_d  = '{default: '0};
      rd_busy_d  = 1'b0;
      timer_d    = '0;
    end
  end

  // Counter and read-tracker state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycles_q   <= '0;
      retired_q  <= '0;
      stalls_q   <= '0;
      prot_err_q <= '0;
      rd_cnt_q   <= '{default: '0};
      wr_cnt_q   <= '{default: '0};
      lat_sum_q  <= '{default: '0};
      lat_max_q  <= '{default: '0};
      rd_busy_q  <= 1'b0;
      rd_sel_q   <= '0;
      timer_q    <= '0;
    end else begin
      cycles_q   <= cycles_d;
      retired_q  <= retired_d;
      stalls_q   <= stalls_d;
      prot_err_q <= prot_err_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      lat_sum_q  <= lat_sum_d;
      lat_max_q  <= lat_max_d;
      rd_busy_q  <= rd_busy_d;
      rd_sel_q   <= rd_sel_d;
      timer_q    <= timer_d;
    end
  end

  // Register map decode from current (pre-edge) counter state
  always_comb begin
    w_rd_val = '0;
    if (reg_idx == IDX_WIDTH'(0)) w_rd_val = cycles_q;
    if (reg_idx == IDX_WIDTH'(1)) w_rd_val = retired_q;
    if (reg_idx == IDX_WIDTH'(2)) w_rd_val = stalls_q;
    if (reg_idx == IDX_WIDTH'(3)) w_rd_val = prot_err_q;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      if (reg_idx == IDX_WIDTH'(4 + 4*s)) w_rd_val = rd_cnt_q[s];
      if (reg_idx == IDX_WIDTH'(5 + 4*s)) w_rd_val = wr_cnt_q[s];
      if (reg_idx == IDX_WIDTH'(6 + 4*s)) w_rd_val = lat_sum_q[s];
      if (reg_idx == IDX_WIDTH'(7 + 4*s)) w_rd_val = lat_max_q[s];
    end
  end

  // Register read port: data and valid pulse one cycle after the request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= reg_rd_en;
      if (reg_rd_en) begin
        rdata_q <= w_rd_val;
      end
    end
  end

  assign reg_rdata  = rdata_q;
  assign reg_rvalid = rvalid_q;
  assign rd_busy    = rd_busy_q;

`ifdef PERF_HANG_DETECT_EN
  localparam logic [CNT_WIDTH:0] c_hang_lim = (CNT_WIDTH+1)'(HANG_LIMIT);
  logic hang_q;

  // Sticky hang flag, set on the edge where the outstanding read's timer reaches the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hang_q <= 1'b0;
    end else if (mon_clear) begin
      hang_q <= 1'b0;
    end else if (rd_busy_d && ({1'b0, timer_d} >= c_hang_lim)) begin
      hang_q <= 1'b1;
    end
  end

  assign hang_irq = hang_q;
`else
  assign hang_irq = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_perf_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_perf_monitor
// Brief    : Self-checking bench for axi_perf_monitor (3 slaves, 8-bit
//            counters). Constant-vector table, directed corner sequences and
//            a randomized phase scored against a transaction-level model.
//            Honours PERF_HANG_DETECT_EN for the hang flag expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_perf_monitor;

  localparam int NS   = 3;
  localparam int CW   = 8;
  localparam int IW   = 8;
  localparam int HL   = 16;
  localparam int CMAX = 255;
`ifdef PERF_HANG_DETECT_EN
  localparam bit HANG_ON = 1'b1;
`else
  localparam bit HANG_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mon_en = 1'b0, mon_clear = 1'b0;
  logic          arvalid = 1'b0, arready = 1'b0;
  logic [1:0]    ar_sel = '0;
  logic          rvalid = 1'b0, rready = 1'b0;
  logic          awvalid = 1'b0, awready = 1'b0;
  logic [1:0]    aw_sel = '0;
  logic          instr_ret = 1'b0, cpu_stall = 1'b0;
  logic          reg_rd_en = 1'b0;
  logic [IW-1:0] reg_idx = '0;
  logic [CW-1:0] reg_rdata;
  logic          reg_rvalid, rd_busy, hang_irq;

  always #5 clk = ~clk;

  axi_perf_monitor #(.NUM_SLAVES(NS), .CNT_WIDTH(CW), .IDX_WIDTH(IW), .HANG_LIMIT(HL)) dut (
    .clk(clk), .rst(rst), .mon_en(mon_en), .mon_clear(mon_clear),
    .arvalid(arvalid), .arready(arready), .ar_sel(ar_sel),
    .rvalid(rvalid), .rready(rready),
    .awvalid(awvalid), .awready(awready), .aw_sel(aw_sel),
    .instr_ret(instr_ret), .cpu_stall(cpu_stall),
    .reg_rd_en(reg_rd_en), .reg_idx(reg_idx), .reg_rdata(reg_rdata),
    .reg_rvalid(reg_rvalid), .rd_busy(rd_busy), .hang_irq(hang_irq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int m_cyc, m_ret, m_stall, m_perr;
  int m_rd [NS];
  int m_wr [NS];
  int m_sum[NS];
  int m_max[NS];
  bit m_busy, m_hang;
  int m_start, m_sel, edge_n;

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_ret = 0; m_stall = 0; m_perr = 0;
    for (int s = 0; s < NS; s++) begin
      m_rd[s] = 0; m_wr[s] = 0; m_sum[s] = 0; m_max[s] = 0;
    end
    m_busy = 0; m_hang = 0; m_start = 0; m_sel = 0; edge_n = 0;
  endtask

  function automatic int model_read(input int idx);
    int s;
    if (idx == 0) return m_cyc;
    if (idx == 1) return m_ret;
    if (idx == 2) return m_stall;
    if (idx == 3) return m_perr;
    if (idx >= 4 + 4*NS) return 0;
    s = (idx - 4) / 4;
    case ((idx - 4) % 4)
      0:       return m_rd[s];
      1:       return m_wr[s];
      2:       return m_sum[s];
      default: return m_max[s];
    endcase
  endfunction

  // One clock edge of the specified behaviour, using the inputs now driven
  task automatic model_step();
    bit a, r, w;
    int pe, lat;
    a = arvalid && arready;
    r = rvalid && rready;
    w = awvalid && awready;
    pe = 0;
    if (mon_clear) begin
      m_cyc = 0; m_ret = 0; m_stall = 0; m_perr = 0;
      for (int s = 0; s < NS; s++) begin
        m_rd[s] = 0; m_wr[s] = 0; m_sum[s] = 0; m_max[s] = 0;
      end
      m_busy = 0; m_hang = 0;
    end else begin
      if (r && m_busy) begin
        lat = sat(edge_n - m_start);
        if (m_sel < NS && mon_en) begin
          m_sum[m_sel] = sat(m_sum[m_sel] + lat);
          if (lat > m_max[m_sel]) m_max[m_sel] = lat;
        end
        m_busy = 0;
      end else if (r && !a) begin
        pe++;
      end
      if (a) begin
        if (m_busy) pe++;
        if (int'(ar_sel) < NS) begin
          if (mon_en) m_rd[ar_sel] = sat(m_rd[ar_sel] + 1);
        end else begin
          pe++;
        end
        m_busy = 1; m_start = edge_n; m_sel = int'(ar_sel);
      end
      if (w) begin
        if (int'(aw_sel) < NS) begin
          if (mon_en) m_wr[aw_sel] = sat(m_wr[aw_sel] + 1);
        end else begin
          pe++;
        end
      end
      if (mon_en) begin
        m_cyc  = sat(m_cyc + 1);
        m_perr = sat(m_perr + pe);
        if (instr_ret) m_ret = sat(m_ret + 1);
        if (cpu_stall) m_stall = sat(m_stall + 1);
      end
      if (HANG_ON && m_busy && sat(edge_n - m_start + 1) >= HL) m_hang = 1;
    end
    edge_n++;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic clear_pulses();
    arvalid = 0; arready = 0; rvalid = 0; rready = 0; awvalid = 0; awready = 0;
    instr_ret = 0; cpu_stall = 0; reg_rd_en = 0; mon_clear = 0;
  endtask

  // Advance one clock; inputs must already be driven
  task automatic tick();
    bit rd;
    int exp_rd;
    rd     = reg_rd_en;
    exp_rd = model_read(int'(reg_idx));
    model_step();
    @(posedge clk);
    #1;
    check("reg_rvalid", {31'd0, reg_rvalid}, {31'd0, rd});
    if (rd) check("reg_rdata_model", {24'd0, reg_rdata}, exp_rd);
    check("rd_busy", {31'd0, rd_busy}, {31'd0, m_busy});
    check("hang_irq", {31'd0, hang_irq}, {31'd0, m_hang});
    clear_pulses();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic cyc(input bit ar, input int asel, input bit r, input bit aw, input int wsel);
    arvalid = ar; arready = ar; ar_sel = 2'(asel);
    rvalid = r; rready = r;
    awvalid = aw; awready = aw; aw_sel = 2'(wsel);
    tick();
  endtask

  task automatic read_reg(input int idx, input int exp);
    reg_rd_en = 1; reg_idx = IW'(idx);
    tick();
    check($sformatf("reg[%0d]", idx), {24'd0, reg_rdata}, exp);
  endtask

  task automatic do_reset();
    rst = 1; clear_pulses(); mon_en = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", {24'd0, reg_rdata}, 0);
    check("rst_rvalid", {31'd0, reg_rvalid}, 0);
    check("rst_busy", {31'd0, rd_busy}, 0);
    check("rst_hang", {31'd0, hang_irq}, 0);
    model_reset();
    rst = 0;
  endtask

  typedef struct { int idx; int exp; } vec_t;
  vec_t tbl[19];

  initial begin
    // Idle-state register map after 10 counted cycles
    tbl[0] = '{0, 10}; tbl[1] = '{1, 0}; tbl[2] = '{2, 0}; tbl[3] = '{3, 0};
    for (int i = 4; i < 16; i++) tbl[i] = '{i, 0};
    tbl[16] = '{16, 0}; tbl[17] = '{200, 0}; tbl[18] = '{0, 10};

    // Idle counting and register map
    do_reset();
    mon_en = 1;
    idle(10);
    mon_en = 0;
    for (int i = 0; i < 19; i++) read_reg(tbl[i].idx, tbl[i].exp);

    // Read latencies 3 and 5 on slave 0
    do_reset();
    mon_en = 1;
    cyc(1, 0, 0, 0, 0); idle(2); cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0); idle(4); cyc(0, 0, 1, 0, 0);
    mon_en = 0;
    read_reg(4, 2); read_reg(6, 8); read_reg(7, 5); read_reg(5, 0);

    // Slave 1: R retires on the same edge a new AR starts; AW counted alongside AR
    mon_en = 1;
    cyc(1, 1, 0, 1, 2); idle(1);
    cyc(1, 1, 1, 0, 0);
    check("busy_after_r_and_ar", {31'd0, rd_busy}, 1);
    idle(2); cyc(0, 0, 1, 0, 0);
    mon_en = 0;
    read_reg(8, 2); read_reg(10, 5); read_reg(11, 3); read_reg(13, 1); read_reg(3, 0);

    // Protocol errors: stray R, abandoned read, out-of-range selects
    do_reset();
    mon_en = 1;
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(0, 0, 1, 0, 0);
    cyc(1, 3, 0, 0, 0);
    read_reg(3, 3);
    idle(1); cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 3);
    mon_en = 0;
    read_reg(3, 4); read_reg(4, 2); read_reg(6, 1); read_reg(7, 1);

    // Saturation at 255 and clear priority over a same-cycle event
    do_reset();
    mon_en = 1;
    for (int i = 0; i < 300; i++) begin
      instr_ret = 1;
      tick();
    end
    read_reg(1, 255); read_reg(0, 255);
    mon_clear = 1; instr_ret = 1; cpu_stall = 1;
    tick();
    mon_en = 0;
    read_reg(1, 0); read_reg(0, 0); read_reg(2, 0);

    // Hang flag on a read that never completes
    do_reset();
    mon_en = 1;
    cyc(1, 0, 0, 0, 0); idle(14);
    check("hang_timer15", {31'd0, hang_irq}, 0);
    idle(1);
    check("hang_timer16", {31'd0, hang_irq}, {31'd0, HANG_ON});
    idle(4); cyc(0, 0, 1, 0, 0);
    check("hang_sticky", {31'd0, hang_irq}, {31'd0, HANG_ON});
    mon_clear = 1; tick();
    check("hang_cleared", {31'd0, hang_irq}, 0);

    // Asynchronous reset in the middle of a read
    do_reset();
    mon_en = 1;
    cyc(1, 1, 0, 0, 0); idle(2);
    check("busy_before_async_rst", {31'd0, rd_busy}, 1);
    #3 rst = 1;
    #1;
    check("busy_async_rst", {31'd0, rd_busy}, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    cyc(0, 0, 1, 0, 0);
    mon_en = 0;
    read_reg(3, 1); read_reg(8, 0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      mon_en    = ($urandom % 8) != 0;
      mon_clear = ($urandom % 64) == 0;
      arvalid   = $urandom % 2; arready = $urandom % 2; ar_sel = 2'($urandom % 4);
      rvalid    = $urandom % 2; rready  = $urandom % 2;
      awvalid   = $urandom % 2; awready = $urandom % 2; aw_sel = 2'($urandom % 4);
      instr_ret = $urandom % 2; cpu_stall = ($urandom % 3) == 0;
      reg_rd_en = ($urandom % 3) == 0;
      reg_idx   = (($urandom % 16) == 0) ? IW'(255) : IW'($urandom % 20);
      tick();
    end
    mon_en = 0;
    for (int i = 0; i < 4 + 4*NS; i++) begin
      reg_rd_en = 1; reg_idx = IW'(i);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
